// File: rtl/freq_gate_counter.sv
// Reciprocal frequency counter core: counts Clock cycles across N rising edges of one selected pin.
// Latency: 3 Clock cycles from pin edge to detection; result registered, flagged by a 1-cycle done_flag.
// Backpressure: none; the result is held in out_value until the next DONE.
module freq_gate_counter #(
    parameter int DATA_WIDTH     = 16,
    parameter int NINPUTS        = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  nSoftReset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] select_input,
    input  logic [DATA_WIDTH-1:0] samples_required,
    input  logic [NINPUTS-1:0]    sig_in,
    output logic [DATA_WIDTH-1:0] out_value,
    output logic                  done_flag,
    output logic                  timeout
);

    typedef enum logic [2:0] {IDLE, ARM, COUNT, DONE, HOLD} state_t;

    localparam int SEL_W = (NINPUTS > 1) ? $clog2(NINPUTS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] NIN_W   = DATA_WIDTH'(NINPUTS);
    localparam logic [TO_W-1:0]       TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] sel_q, sel_nxt;
    logic [DATA_WIDTH-1:0] n_q, n_nxt;
    logic [DATA_WIDTH-1:0] cycle_cnt, cyc_nxt, cyc_inc;
    logic [DATA_WIDTH-1:0] edge_cnt, edge_nxt, edge_inc;
    logic [TO_W-1:0]       to_cnt, to_nxt;
    logic [DATA_WIDTH-1:0] out_nxt;
    logic                  to_flag_nxt;
    logic [DATA_WIDTH-1:0] sel_mux;
    logic                  pin, s1, s2, s3, edge_det;

    // While idle the synchroniser follows the live selection so no stale edge appears on arming
    assign sel_mux  = (state == IDLE) ? select_input : sel_q;
    assign pin      = (sel_mux < NIN_W) ? sig_in[sel_mux[SEL_W-1:0]] : 1'b0;
    assign edge_det = s2 & ~s3;
    assign cyc_inc  = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 1'b1;
    assign edge_inc = edge_cnt + 1'b1;

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel_q;
        n_nxt       = n_q;
        cyc_nxt     = cycle_cnt;
        edge_nxt    = edge_cnt;
        to_nxt      = to_cnt;
        out_nxt     = out_value;
        to_flag_nxt = timeout;
        case (state)
            IDLE: begin
                if (enable) begin
                    sel_nxt     = select_input;
                    n_nxt       = samples_required;
                    to_flag_nxt = 1'b0;
                    cyc_nxt     = '0;
                    edge_nxt    = '0;
                    to_nxt      = '0;
                    if (samples_required == '0) begin
                        state_nxt = DONE;
                        out_nxt   = '0;
                    end else begin
                        state_nxt = ARM;
                    end
                end
            end
            ARM: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (edge_det) begin
                    state_nxt = COUNT;
                    cyc_nxt   = '0;
                    edge_nxt  = '0;
                    to_nxt    = '0;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt   = DONE;
                    out_nxt     = '1;
                    to_flag_nxt = 1'b1;
                end else begin
                    to_nxt = to_cnt + 1'b1;
                end
            end
            COUNT: begin
                cyc_nxt = cyc_inc;
                // Nth edge beats a coincident timeout
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (edge_det && (edge_inc == n_q)) begin
                    state_nxt = DONE;
                    out_nxt   = cyc_inc;
                end else if (edge_det) begin
                    edge_nxt = edge_inc;
                    to_nxt   = '0;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt   = DONE;
                    out_nxt     = '1;
                    to_flag_nxt = 1'b1;
                end else begin
                    to_nxt = to_cnt + 1'b1;
                end
            end
            DONE:    state_nxt = HOLD;
            HOLD:    if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            sel_q     <= '0;
            n_q       <= '0;
            cycle_cnt <= '0;
            edge_cnt  <= '0;
            to_cnt    <= '0;
            out_value <= '0;
            done_flag <= 1'b0;
            timeout   <= 1'b0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
        end else if (!nSoftReset) begin
            state     <= IDLE;
            sel_q     <= '0;
            n_q       <= '0;
            cycle_cnt <= '0;
            edge_cnt  <= '0;
            to_cnt    <= '0;
            out_value <= '0;
            done_flag <= 1'b0;
            timeout   <= 1'b0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel_q     <= sel_nxt;
            n_q       <= n_nxt;
            cycle_cnt <= cyc_nxt;
            edge_cnt  <= edge_nxt;
            to_cnt    <= to_nxt;
            out_value <= out_nxt;
            done_flag <= (state_nxt == DONE);
            timeout   <= to_flag_nxt;
            s1        <= pin;
            s2        <= s1;
            s3        <= s2;
        end
    end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: 50 MHz Clock, 1 MHz on pin 2, ~1.67 MHz on pin 5, short timeout.
module tb_freq_gate_counter;

    typedef struct {
        logic [15:0] val;
        logic        to;
    } exp_t;

    logic        Clock;
    logic        nReset;
    logic        nSoftReset;
    logic        enable;
    logic [15:0] select_input;
    logic [15:0] samples_required;
    logic [7:0]  sig_in;
    logic [15:0] out_value;
    logic        done_flag;
    logic        timeout;
    logic        p2, p5;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   c;
    int   d0;

    freq_gate_counter #(
        .DATA_WIDTH(16),
        .NINPUTS(8),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .Clock(Clock),
        .nReset(nReset),
        .nSoftReset(nSoftReset),
        .enable(enable),
        .select_input(select_input),
        .samples_required(samples_required),
        .sig_in(sig_in),
        .out_value(out_value),
        .done_flag(done_flag),
        .timeout(timeout)
    );

    initial Clock = 1'b0;
    always #10 Clock = ~Clock;

    // Pin 2: 1000 ns period (50 clocks); pin 5: 600 ns period (30 clocks)
    initial begin
        p2 = 1'b0;
        #3;
        forever #500 p2 = ~p2;
    end
    initial begin
        p5 = 1'b0;
        #7;
        forever #300 p5 = ~p5;
    end
    assign sig_in = {2'b00, p5, 2'b00, p2, 2'b00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clock) begin
        exp_t e;
        if (done_flag) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done_flag), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_value", 32'(out_value), 32'(e.val));
                chk("timeout_flag", 32'(timeout), 32'(e.to));
            end
        end
    end

    task automatic start(input logic [15:0] sel, input logic [15:0] n);
        @(negedge Clock);
        select_input     = sel;
        samples_required = n;
        enable           = 1'b1;
    endtask

    task automatic stop();
        @(negedge Clock);
        enable = 1'b0;
        repeat (2) @(negedge Clock);
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < maxc) begin
            @(negedge Clock);
            cyc++;
            seen = done_flag;
        end
        chk("done_seen", 32'(seen), 32'd1);
        @(negedge Clock);
        chk("done_one_cycle", 32'(done_flag), 32'd0);
    endtask

    initial begin
        nReset           = 1'b0;
        nSoftReset       = 1'b1;
        enable           = 1'b0;
        select_input     = 16'd0;
        samples_required = 16'd0;
        #15;
        chk("rst_out_value", 32'(out_value), 32'd0);
        chk("rst_done", 32'(done_flag), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        #30;
        nReset = 1'b1;
        repeat (3) @(negedge Clock);

        // 1 MHz over 4 periods
        start(16'd2, 16'd4);
        sb.push_back('{16'd200, 1'b0});
        wait_done(400, c);

        // enable held after done: no restart
        d0 = done_cnt;
        repeat (300) @(negedge Clock);
        chk("hold_no_redone", 32'(done_cnt), 32'(d0));
        stop();
        start(16'd2, 16'd4);
        sb.push_back('{16'd200, 1'b0});
        wait_done(400, c);

        // abort mid-measurement, then measure afresh
        stop();
        start(16'd2, 16'd4);
        repeat (120) @(negedge Clock);
        enable = 1'b0;
        d0 = done_cnt;
        repeat (300) @(negedge Clock);
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        chk("abort_keeps_out", 32'(out_value), 32'd200);
        start(16'd2, 16'd4);
        sb.push_back('{16'd200, 1'b0});
        wait_done(400, c);

        // out-of-range select: constant input, timeout
        stop();
        start(16'd9, 16'd4);
        sb.push_back('{16'hFFFF, 1'b1});
        wait_done(400, c);
        chk("timeout_latency", 32'(c), 32'd101);
        stop();
        chk("timeout_held_idle", 32'(timeout), 32'd1);

        // N=0: immediate result, timeout cleared
        start(16'd9, 16'd0);
        sb.push_back('{16'd0, 1'b0});
        wait_done(10, c);
        chk("n0_latency", 32'(c), 32'd1);

        // select/N changes during a measurement are ignored
        stop();
        start(16'd5, 16'd3);
        sb.push_back('{16'd90, 1'b0});
        repeat (40) @(negedge Clock);
        select_input     = 16'd2;
        samples_required = 16'd1;
        wait_done(400, c);

        // synchronous soft reset mid-COUNT
        stop();
        start(16'd5, 16'd3);
        repeat (50) @(negedge Clock);
        nSoftReset = 1'b0;
        #1;
        chk("soft_not_async", 32'(out_value), 32'd90);
        @(posedge Clock);
        #1;
        chk("soft_out_value", 32'(out_value), 32'd0);
        chk("soft_done", 32'(done_flag), 32'd0);
        @(negedge Clock);
        nSoftReset = 1'b1;
        enable     = 1'b0;
        repeat (2) @(negedge Clock);

        // asynchronous reset mid-COUNT between edges
        start(16'd2, 16'd4);
        sb.push_back('{16'd200, 1'b0});
        wait_done(400, c);
        stop();
        start(16'd2, 16'd4);
        repeat (100) @(negedge Clock);
        d0 = done_cnt;
        @(posedge Clock);
        #5;
        nReset = 1'b0;
        #1;
        chk("arst_out_value", 32'(out_value), 32'd0);
        chk("arst_done", 32'(done_flag), 32'd0);
        chk("arst_timeout", 32'(timeout), 32'd0);
        enable = 1'b0;
        #20;
        nReset = 1'b1;
        repeat (300) @(negedge Clock);
        chk("arst_no_done", 32'(done_cnt), 32'(d0));

        start(16'd5, 16'd3);
        sb.push_back('{16'd90, 1'b0});
        wait_done(400, c);
        stop();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
